// File: rtl/pwm_cfg_pkg.sv
// Shared definitions for the PWM configuration sequencer: default register map,
// FSM state encoding, control-word bit positions and ramp arithmetic.
package pwm_cfg_pkg;

  localparam logic [15:0] DEF_ADDR_CTRL   = 16'd0;
  localparam logic [15:0] DEF_ADDR_DIV    = 16'd2;
  localparam logic [15:0] DEF_ADDR_PERIOD = 16'd4;
  localparam logic [15:0] DEF_ADDR_DC     = 16'd6;

  localparam int CTRL_CLK_SEL_BIT = 0;
  localparam int CTRL_MODE_BIT    = 1;
  localparam int CTRL_CNT_EN_BIT  = 2;
  localparam int CTRL_CONT_BIT    = 3;
  localparam int CTRL_OUT_EN_BIT  = 4;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_W_DIV     = 3'd1,
    S_W_PER     = 3'd2,
    S_W_DC      = 3'd3,
    S_W_CTRL    = 3'd4,
    S_RAMP_WAIT = 3'd5,
    S_W_DC_R    = 3'd6,
    S_DONE      = 3'd7
  } state_e;

  // Moves cur toward tgt by at most step; the step is clamped to the distance so it never overshoots.
  function automatic logic [15:0] step_toward(input logic [15:0] cur,
                                              input logic [15:0] tgt,
                                              input logic [15:0] step);
    logic [15:0] diff;
    logic [15:0] amt;
    if (tgt >= cur) begin
      diff = tgt - cur;
    end else begin
      diff = cur - tgt;
    end
    amt = (step < diff) ? step : diff;
    if (tgt >= cur) begin
      return cur + amt;
    end else begin
      return cur - amt;
    end
  endfunction

endpackage

// File: rtl/pwm_cfg_sequencer_wb_single_write.sv
// Single Wishbone write engine: launches one write on start, holds adr/data until ack,
// and abandons the cycle if no ack arrives within TIMEOUT strobe cycles.
module wb_single_write
  import pwm_cfg_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_start,
  input  logic [15:0] i_adr,
  input  logic [15:0] i_data,
  input  logic        i_ack,
  output logic        o_cyc,
  output logic        o_stb,
  output logic        o_we,
  output logic [15:0] o_adr,
  output logic [15:0] o_data,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_timeout
);

  localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

  logic        stb_q, stb_d;
  logic [15:0] adr_q, adr_d;
  logic [15:0] data_q, data_d;
  logic [15:0] cnt_q, cnt_d;
  logic        ack_s, to_s;

  // An ack in the final allowed cycle wins over the timeout.
  assign ack_s = stb_q & i_ack;
  assign to_s  = stb_q & ~i_ack & (cnt_q == TO_LAST);

  // Transaction launch, hold and termination.
  always_comb begin
    stb_d  = stb_q;
    adr_d  = adr_q;
    data_d = data_q;
    cnt_d  = cnt_q;
    if (!stb_q) begin
      cnt_d = 16'd0;
      if (i_start) begin
        stb_d  = 1'b1;
        adr_d  = i_adr;
        data_d = i_data;
      end else begin
        stb_d = 1'b0;
      end
    end else if (ack_s || to_s) begin
      stb_d = 1'b0;
      cnt_d = 16'd0;
    end else begin
      cnt_d = cnt_q + 16'd1;
    end
  end

  // Bus registers with synchronous active-low reset.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      stb_q  <= 1'b0;
      adr_q  <= 16'd0;
      data_q <= 16'd0;
      cnt_q  <= 16'd0;
    end else begin
      stb_q  <= stb_d;
      adr_q  <= adr_d;
      data_q <= data_d;
      cnt_q  <= cnt_d;
    end
  end

  assign o_cyc     = stb_q;
  assign o_stb     = stb_q;
  assign o_we      = stb_q;
  assign o_adr     = adr_q;
  assign o_data    = data_q;
  assign o_busy    = stb_q;
  assign o_done    = ack_s;
  assign o_timeout = to_s;

endmodule

// File: rtl/pwm_cfg_sequencer.sv
// Wishbone master that programs the PWM register file from one command:
// divisor, period, duty, then control, with an optional stepped duty ramp.
module pwm_cfg_sequencer
  import pwm_cfg_pkg::*;
#(
  parameter logic [15:0] ADDR_CTRL   = DEF_ADDR_CTRL,
  parameter logic [15:0] ADDR_DIV    = DEF_ADDR_DIV,
  parameter logic [15:0] ADDR_PERIOD = DEF_ADDR_PERIOD,
  parameter logic [15:0] ADDR_DC     = DEF_ADDR_DC,
  parameter int          TIMEOUT     = 16
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_cmd_valid,
  output logic        o_cmd_ready,
  input  logic [15:0] i_cmd_ctrl,
  input  logic [15:0] i_cmd_div,
  input  logic [15:0] i_cmd_period,
  input  logic [15:0] i_cmd_duty,
  input  logic [15:0] i_cmd_step,
  input  logic [15:0] i_cmd_interval,
  output logic        o_wb_cyc,
  output logic        o_wb_stb,
  output logic        o_wb_we,
  output logic [15:0] o_wb_adr,
  output logic [15:0] o_wb_data,
  input  logic        i_wb_ack,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_err,
  output logic [15:0] o_cur_duty
);

  state_e      state_q, state_d;
  logic [15:0] ctrl_q, div_q, per_q, target_q, step_q, ival_q;
  logic [15:0] cur_q, cur_d;
  logic [15:0] wait_q, wait_d;
  logic        err_q, err_d;
  logic        done_q, busy_q, ready_q;
  logic        accept_s, start_s, is_write_s;
  logic [15:0] wr_adr_s, wr_data_s;
  logic        eng_busy_s, eng_done_s, eng_to_s;

  assign accept_s = i_cmd_valid & ready_q;

  wb_single_write #(.TIMEOUT(TIMEOUT)) u_wr (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_start   (start_s),
    .i_adr     (wr_adr_s),
    .i_data    (wr_data_s),
    .i_ack     (i_wb_ack),
    .o_cyc     (o_wb_cyc),
    .o_stb     (o_wb_stb),
    .o_we      (o_wb_we),
    .o_adr     (o_wb_adr),
    .o_data    (o_wb_data),
    .o_busy    (eng_busy_s),
    .o_done    (eng_done_s),
    .o_timeout (eng_to_s)
  );

  // Write address/data selection; in IDLE the first write launches straight from the command inputs.
  always_comb begin
    wr_adr_s   = ADDR_DIV;
    wr_data_s  = i_cmd_div;
    is_write_s = 1'b0;
    case (state_q)
      S_W_DIV:  begin wr_adr_s = ADDR_DIV;    wr_data_s = div_q;  is_write_s = 1'b1; end
      S_W_PER:  begin wr_adr_s = ADDR_PERIOD; wr_data_s = per_q;  is_write_s = 1'b1; end
      S_W_CTRL: begin wr_adr_s = ADDR_CTRL;   wr_data_s = ctrl_q; is_write_s = 1'b1; end
      S_W_DC, S_W_DC_R: begin
        wr_adr_s   = ADDR_DC;
        wr_data_s  = (step_q == 16'd0) ? target_q : step_toward(cur_q, target_q, step_q);
        is_write_s = 1'b1;
      end
      default: begin wr_adr_s = ADDR_DIV; wr_data_s = i_cmd_div; is_write_s = 1'b0; end
    endcase
    start_s = accept_s | (is_write_s & ~eng_busy_s);
  end

  // Next-state, duty tracking, error and ramp-interval logic.
  always_comb begin
    state_d = state_q;
    cur_d   = cur_q;
    err_d   = err_q;
    wait_d  = 16'd0;
    if (eng_done_s && (state_q == S_W_DC || state_q == S_W_DC_R)) begin
      cur_d = o_wb_data;
    end else begin
      cur_d = cur_q;
    end
    if (accept_s) begin
      err_d = 1'b0;
    end else if (eng_to_s) begin
      err_d = 1'b1;
    end else begin
      err_d = err_q;
    end
    case (state_q)
      S_IDLE:  state_d = accept_s ? S_W_DIV : S_IDLE;
      S_W_DIV: state_d = eng_to_s ? S_DONE : (eng_done_s ? S_W_PER  : S_W_DIV);
      S_W_PER: state_d = eng_to_s ? S_DONE : (eng_done_s ? S_W_DC   : S_W_PER);
      S_W_DC:  state_d = eng_to_s ? S_DONE : (eng_done_s ? S_W_CTRL : S_W_DC);
      S_W_CTRL, S_W_DC_R: begin
        if (eng_to_s) begin
          state_d = S_DONE;
        end else if (eng_done_s) begin
          state_d = (cur_d != target_q) ? S_RAMP_WAIT : S_DONE;
        end else begin
          state_d = state_q;
        end
      end
      S_RAMP_WAIT: begin
        wait_d  = wait_q + 16'd1;
        state_d = (wait_q == ival_q - 16'd1) ? S_W_DC_R : S_RAMP_WAIT;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // FSM state and status registers.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q <= S_IDLE;
      cur_q   <= 16'd0;
      err_q   <= 1'b0;
      wait_q  <= 16'd0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
      ready_q <= 1'b1;
    end else begin
      state_q <= state_d;
      cur_q   <= cur_d;
      err_q   <= err_d;
      wait_q  <= wait_d;
      done_q  <= (state_d == S_DONE);
      busy_q  <= (state_d != S_IDLE);
      ready_q <= (state_d == S_IDLE);
    end
  end

  // Command latch; target duty is clamped to the period.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      ctrl_q   <= 16'd0;
      div_q    <= 16'd0;
      per_q    <= 16'd0;
      target_q <= 16'd0;
      step_q   <= 16'd0;
      ival_q   <= 16'd1;
    end else if (accept_s) begin
      ctrl_q   <= i_cmd_ctrl;
      div_q    <= i_cmd_div;
      per_q    <= i_cmd_period;
      target_q <= (i_cmd_duty > i_cmd_period) ? i_cmd_period : i_cmd_duty;
      step_q   <= i_cmd_step;
      ival_q   <= (i_cmd_interval == 16'd0) ? 16'd1 : i_cmd_interval;
    end else begin
      ctrl_q   <= ctrl_q;
      div_q    <= div_q;
      per_q    <= per_q;
      target_q <= target_q;
      step_q   <= step_q;
      ival_q   <= ival_q;
    end
  end

  assign o_cmd_ready = ready_q;
  assign o_busy      = busy_q;
  assign o_done      = done_q;
  assign o_err       = err_q;
  assign o_cur_duty  = cur_q;

endmodule

// File: tb/tb_pwm_cfg_sequencer.sv
// Directed bench for pwm_cfg_sequencer with a 1-cycle-latency Wishbone slave model
// that can be muted to exercise the ack timeout.
module tb_pwm_cfg_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid, cmd_ready;
  logic [15:0] cmd_ctrl, cmd_div, cmd_period, cmd_duty, cmd_step, cmd_interval;
  logic        wb_cyc, wb_stb, wb_we, wb_ack;
  logic [15:0] wb_adr, wb_data, cur_duty;
  logic        busy, done, err;
  logic        ack_en;

  int n_asserts = 0;
  int n_fails   = 0;
  int wr_adr[$];
  int wr_dat[$];
  int wr_cyc[$];
  int done_c, ready_c, stb_hi;
  logic busy1, err1, ready1;

  always #5 clk = ~clk;

  pwm_cfg_sequencer dut (
    .i_clk          (clk),
    .i_rst_n        (rst_n),
    .i_cmd_valid    (cmd_valid),
    .o_cmd_ready    (cmd_ready),
    .i_cmd_ctrl     (cmd_ctrl),
    .i_cmd_div      (cmd_div),
    .i_cmd_period   (cmd_period),
    .i_cmd_duty     (cmd_duty),
    .i_cmd_step     (cmd_step),
    .i_cmd_interval (cmd_interval),
    .o_wb_cyc       (wb_cyc),
    .o_wb_stb       (wb_stb),
    .o_wb_we        (wb_we),
    .o_wb_adr       (wb_adr),
    .o_wb_data      (wb_data),
    .i_wb_ack       (wb_ack),
    .o_busy         (busy),
    .o_done         (done),
    .o_err          (err),
    .o_cur_duty     (cur_duty)
  );

  // Slave: ack one cycle after stb rises, for one cycle.
  always @(posedge clk) begin
    if (!rst_n) wb_ack <= 1'b0;
    else        wb_ack <= ack_en && wb_stb && !wb_ack;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic run_cmd(input logic [15:0] ctrl, input logic [15:0] div, input logic [15:0] per,
                         input logic [15:0] duty, input logic [15:0] step, input logic [15:0] ival);
    wr_adr.delete(); wr_dat.delete(); wr_cyc.delete();
    done_c = 0; ready_c = 0; stb_hi = 0;
    @(negedge clk);
    cmd_ctrl = ctrl; cmd_div = div; cmd_period = per;
    cmd_duty = duty; cmd_step = step; cmd_interval = ival;
    cmd_valid = 1'b1;
    @(posedge clk);
    for (int c = 1; c <= 400; c++) begin
      @(negedge clk);
      if (c == 1) begin
        cmd_valid = 1'b0;
        busy1 = busy; err1 = err; ready1 = cmd_ready;
      end
      if (wb_stb) stb_hi++;
      if (wb_stb && wb_ack) begin
        wr_adr.push_back(int'(wb_adr));
        wr_dat.push_back(int'(wb_data));
        wr_cyc.push_back(c);
      end
      if (done) done_c = c;
      if (done_c != 0 && cmd_ready) begin
        ready_c = c;
        break;
      end
    end
    check("cmd_completes_in_budget", {31'd0, ready_c != 0}, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int exp_adr[4];
    int exp_dat[4];
    exp_adr = '{2, 4, 6, 0};
    exp_dat = '{1, 8, 4, 22};
    rst_n = 1'b0; ack_en = 1'b1; cmd_valid = 1'b0;
    cmd_ctrl = 16'd0; cmd_div = 16'd0; cmd_period = 16'd0;
    cmd_duty = 16'd0; cmd_step = 16'd0; cmd_interval = 16'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_cyc",   {31'd0, wb_cyc}, 32'd0);
    check("rst_stb",   {31'd0, wb_stb}, 32'd0);
    check("rst_we",    {31'd0, wb_we}, 32'd0);
    check("rst_adr",   {16'd0, wb_adr}, 32'd0);
    check("rst_data",  {16'd0, wb_data}, 32'd0);
    check("rst_ready", {31'd0, cmd_ready}, 32'd1);
    check("rst_busy",  {31'd0, busy}, 32'd0);
    check("rst_done",  {31'd0, done}, 32'd0);
    check("rst_err",   {31'd0, err}, 32'd0);
    check("rst_cur",   {16'd0, cur_duty}, 32'd0);
    rst_n = 1'b1;

    // Immediate command: DIV, PER, DC, CTRL at 3-cycle pitch.
    run_cmd(16'h0016, 16'd1, 16'd8, 16'd4, 16'd0, 16'd0);
    check("imm_busy_c1",  {31'd0, busy1}, 32'd1);
    check("imm_ready_c1", {31'd0, ready1}, 32'd0);
    check("imm_nwrites",  wr_adr.size(), 32'd4);
    for (int i = 0; i < 4; i++) begin
      check("imm_adr", wr_adr[i], exp_adr[i]);
      check("imm_dat", wr_dat[i], exp_dat[i]);
      check("imm_ack_cycle", wr_cyc[i], 2 + 3 * i);
    end
    check("imm_done_cycle",  done_c, 32'd12);
    check("imm_ready_cycle", ready_c, 32'd13);
    check("imm_cur",         {16'd0, cur_duty}, 32'd4);

    // Ramp up 4 -> 12, step 3, interval 5.
    run_cmd(16'h0016, 16'd1, 16'd100, 16'd12, 16'd3, 16'd5);
    check("up_nwrites", wr_adr.size(), 32'd6);
    check("up_dc0",     wr_dat[2], 32'd7);
    check("up_dc1",     wr_dat[4], 32'd10);
    check("up_dc2",     wr_dat[5], 32'd12);
    check("up_adr_r1",  wr_adr[4], 32'd6);
    check("up_adr_r2",  wr_adr[5], 32'd6);
    check("up_gap1",    wr_cyc[4] - wr_cyc[3], 32'd8);
    check("up_gap2",    wr_cyc[5] - wr_cyc[4], 32'd8);
    check("up_done",    done_c, 32'd28);
    check("up_cur",     {16'd0, cur_duty}, 32'd12);

    // Ramp down 12 -> 2, step 4, interval 0 behaves as 1.
    run_cmd(16'h0016, 16'd1, 16'd100, 16'd2, 16'd4, 16'd0);
    check("dn_nwrites", wr_adr.size(), 32'd6);
    check("dn_dc0",     wr_dat[2], 32'd8);
    check("dn_dc1",     wr_dat[4], 32'd4);
    check("dn_dc2",     wr_dat[5], 32'd2);
    check("dn_gap1",    wr_cyc[4] - wr_cyc[3], 32'd4);
    check("dn_done",    done_c, 32'd20);
    check("dn_cur",     {16'd0, cur_duty}, 32'd2);

    // Duty above period is clamped to the period.
    run_cmd(16'h0016, 16'd3, 16'd8, 16'd20, 16'd0, 16'd0);
    check("clamp_per", wr_dat[1], 32'd8);
    check("clamp_dc",  wr_dat[2], 32'd8);
    check("clamp_cur", {16'd0, cur_duty}, 32'd8);

    // Silent slave: timeout after 16 strobe cycles.
    ack_en = 1'b0;
    run_cmd(16'h0016, 16'd5, 16'd50, 16'd30, 16'd0, 16'd0);
    check("to_nwrites", wr_adr.size(), 32'd0);
    check("to_stb_hi",  stb_hi, 32'd16);
    check("to_done",    done_c, 32'd17);
    check("to_err",     {31'd0, err}, 32'd1);
    check("to_cur",     {16'd0, cur_duty}, 32'd8);
    ack_en = 1'b1;

    // Next accepted command clears the sticky error.
    run_cmd(16'h0006, 16'd2, 16'd10, 16'd10, 16'd0, 16'd0);
    check("clr_err_c1",  {31'd0, err1}, 32'd0);
    check("clr_nwrites", wr_adr.size(), 32'd4);
    check("clr_cur",     {16'd0, cur_duty}, 32'd10);

    // Reset while the period write is on the bus.
    @(negedge clk);
    cmd_ctrl = 16'h0016; cmd_div = 16'd7; cmd_period = 16'd9;
    cmd_duty = 16'd3; cmd_step = 16'd0; cmd_interval = 16'd0;
    cmd_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("mid_stb_before", {31'd0, wb_stb}, 32'd1);
    check("mid_adr_before", {16'd0, wb_adr}, 32'd4);
    rst_n = 1'b0;
    @(negedge clk);
    check("mid_stb_after",   {31'd0, wb_stb}, 32'd0);
    check("mid_cyc_after",   {31'd0, wb_cyc}, 32'd0);
    check("mid_busy_after",  {31'd0, busy}, 32'd0);
    check("mid_ready_after", {31'd0, cmd_ready}, 32'd1);
    check("mid_cur_after",   {16'd0, cur_duty}, 32'd0);
    rst_n = 1'b1;

    run_cmd(16'h0016, 16'd4, 16'd20, 16'd5, 16'd0, 16'd0);
    check("post_rst_nwrites", wr_adr.size(), 32'd4);
    check("post_rst_div",     wr_dat[0], 32'd4);
    check("post_rst_cur",     {16'd0, cur_duty}, 32'd5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
    $finish;
  end

endmodule

// File: doc/pwm_cfg_sequencer.md
# pwm_cfg_sequencer

Wishbone master that programs the `top_pwm` register file from a single command interface, replacing hand-driven bus writes. It writes divisor, period, duty and control in a fixed safe order. It can optionally ramp the duty register from its last written value to a target in fixed steps. It sits between the system controller and the PWM timer's slave port and owns that bus exclusively.

## Interface
Parameters:
- `ADDR_CTRL`, 16'd0, control register address
- `ADDR_DIV`, 16'd2, divisor register address
- `ADDR_PERIOD`, 16'd4, period register address
- `ADDR_DC`, 16'd6, duty register address
- `TIMEOUT`, 16, maximum cycles stb may wait for ack

Ports:
- `i_clk`  in  1  single clock for all logic
- `i_rst_n`  in  1  synchronous active-low reset
- `i_cmd_valid`  in  1  command present
- `o_cmd_ready`  out  1  sequencer can accept a command (IDLE only)
- `i_cmd_ctrl`  in  16  control word
- `i_cmd_div`  in  16  divisor
- `i_cmd_period`  in  16  period
- `i_cmd_duty`  in  16  target duty
- `i_cmd_step`  in  16  ramp step; 0 = write target directly
- `i_cmd_interval`  in  16  cycles between ramp writes; 0 is treated as 1
- `o_wb_cyc`, `o_wb_stb`, `o_wb_we`  out  1 each  WB master strobes
- `o_wb_adr`  out  16  WB address
- `o_wb_data`  out  16  WB write data
- `i_wb_ack`  in  1  WB acknowledge
- `o_busy`  out  1  high in every state except IDLE
- `o_done`  out  1  one-cycle pulse when a command completes or aborts
- `o_err`  out  1  ack timeout occurred; sticky until next accepted command
- `o_cur_duty`  out  16  last duty value acknowledged by the slave

## Operation
- All command fields are latched on `i_cmd_valid && o_cmd_ready`. `o_err` clears at acceptance.
- Target duty = min(`i_cmd_duty`, `i_cmd_period`).
- States: IDLE → W_DIV → W_PER → W_DC → W_CTRL → (RAMP_WAIT → W_DC_R)* → DONE → IDLE.
- Control is written last, so enables take effect only after timing is configured.
- W_DC writes data depending on step:
  - step = 0: the target.
  - step ≠ 0: `o_cur_duty` moved one step toward the target, clamped so it never overshoots.
- After W_CTRL:
  - If `o_cur_duty` ≠ target: enter RAMP_WAIT, count the interval, then W_DC_R writes the next step. Repeat until `o_cur_duty` equals the target.
  - Otherwise: go to DONE.
- `o_cur_duty` updates only on an acked DC write.
- Ramp arithmetic is 16-bit unsigned. The step is computed as min(step, |target − cur|), so no wrap-around is possible.
- Every W_* state performs one WB write: `cyc`/`stb`/`we` high, `adr`/`data` registered and held stable until ack.
- If ack is not seen within `TIMEOUT` cycles of stb assertion:
  - drop `cyc`/`stb`
  - set `o_err`
  - go to DONE (`o_done` still pulses)
  - leave `o_cur_duty` unchanged
- `i_cmd_valid` is ignored while busy. A new command is never queued.
- Reset mid-transaction: `cyc`/`stb` drop at the reset edge and the FSM returns to IDLE. No partial write is retried.

## Timing
- Reset values: all WB outputs 0, `o_cmd_ready` 1, `o_busy` 0, `o_done` 0, `o_err` 0, `o_cur_duty` 0.
- Acceptance edge = cycle 0. The first stb is high in cycle 1.
- Write protocol:
  - ack is sampled on the edge; stb drops the cycle after ack.
  - One idle bus cycle follows between writes.
  - With a 1-cycle-latency slave, each write is 3 cycles: write k has stb in cycles 1+3k..2+3k.
- Immediate command (step = 0, 1-cycle ack): `o_done` is high in cycle 12 and `o_cmd_ready` returns in cycle 13.
- RAMP_WAIT lasts exactly `max(interval,1)` cycles. It starts the cycle after the previous DC write's stb drops.
- An ack arriving in the same cycle as the timeout expiry counts as ack, not an error.

## Structure
- Shared package `pwm_cfg_pkg` holds:
  - the default register address constants
  - the FSM state enum
  - control-word bit positions (clock select, mode, counter enable, continuous, output enable)
- Sub-module `wb_single_write`: a one-transaction WB write engine.
  - Inputs: start, adr, data.
  - Outputs: done, timeout.
  - Contains the timeout counter.
  - The sequencer FSM instantiates it once.

## Test plan
- Reset → all outputs at reset values, `o_cmd_ready`=1; reset asserted mid-W_PER drops stb on the next edge.
- Immediate cmd (ctrl=0x16, div=1, period=8, duty=4, step=0), 1-cycle ack → writes in order adr 2,4,6,0 with data 1,8,4,0x16; `o_done` in cycle 12; `o_cur_duty`=4.
- Duty clamp: period=8, duty=20 → DC write data=8.
- Ramp up: `o_cur_duty`=4, target 12, step=3, interval=5 → DC writes 7, 10, 12; 5-cycle gaps in RAMP_WAIT; no overshoot.
- Ramp down: `o_cur_duty`=12, target 2, step=4 → DC writes 8, 4, 2.
- Timeout: slave never acks, `TIMEOUT`=16 → stb drops after 16 cycles, `o_err`=1, `o_done` pulses, `o_cur_duty` unchanged; next accepted cmd clears `o_err`.
